// File: rtl/ofm_pkg.sv
// Shared constants, FSM state type and kernel-count decode for the OFM writeback packer.
package ofm_pkg;

  localparam int unsigned ROW_LEN       = 61;
  localparam int unsigned NUM_ROWS      = 61;
  localparam int unsigned OFM_PLANE     = ROW_LEN * NUM_ROWS;
  localparam int unsigned BEATS_PER_ROW = (ROW_LEN + 1) / 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRAIN,
    ST_DONE
  } ofm_state_e;

  function automatic logic [5:0] decode_kernels(input logic [2:0] cfg);
    case (cfg)
      3'd0:    decode_kernels = 6'd8;
      3'd1:    decode_kernels = 6'd16;
      3'd2:    decode_kernels = 6'd24;
      default: decode_kernels = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/ofm_wr_fifo.sv
// Packed-word FIFO for the OFM writeback path; flush clears pointers, push while full is
// accepted only when a pop happens in the same cycle.
module ofm_wr_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ofm_writeback_packer.sv
// Packs the two-lane per-row convolution output stream into 4-lane, address-tagged OFM SRAM words.
// Build option OFM_RELU_EN clamps negative lanes to zero before packing.
module ofm_writeback_packer #(
  parameter int unsigned LEN_OUT    = 25,
  parameter int unsigned ROW_LEN    = ofm_pkg::ROW_LEN,
  parameter int unsigned NUM_ROWS   = ofm_pkg::NUM_ROWS,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                in_cfg_co,
  input  logic                      in_start,
  input  logic                      in_write_ctl,
  input  logic signed [LEN_OUT-1:0] in_data0,
  input  logic signed [LEN_OUT-1:0] in_data1,
  output logic                      out_wr_valid,
  input  logic                      out_wr_ready,
  output logic [ADDR_W-1:0]         out_wr_addr,
  output logic [4*LEN_OUT-1:0]      out_wr_data,
  output logic [3:0]                out_wr_mask,
  output logic                      out_overflow,
  output logic                      out_done
);

  import ofm_pkg::*;

  localparam int unsigned BEATS  = (ROW_LEN + 1) / 2;
  localparam int unsigned BW     = $clog2(BEATS);
  localparam int unsigned RW     = $clog2(NUM_ROWS);
  localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WORD_W = ADDR_W + 4 * LEN_OUT + 4;

  ofm_state_e          state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [RW-1:0]       row_q, row_d;
  logic [5:0]          kernel_q, kernel_d;
  logic [5:0]          kcount_q, kcount_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_OUT-1:0]  carry0_q, carry0_d;
  logic [LEN_OUT-1:0]  carry1_q, carry1_d;
  logic [LEN_OUT-1:0]  carry2_q, carry2_d;
  logic                tail_q, tail_d;
  logic                last_tail_q, last_tail_d;
  logic                overflow_q, overflow_d;

  logic [LEN_OUT-1:0]   lane0, lane1;
  logic                 beat_fire, last_row, last_kernel;
  logic                 push, pop, flush;
  logic [ADDR_W-1:0]    push_addr;
  logic [4*LEN_OUT-1:0] push_data;
  logic [3:0]           push_mask;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [WORD_W-1:0]    rd_word;

  function automatic logic [LEN_OUT-1:0] lane_fn(input logic [LEN_OUT-1:0] v);
`ifdef OFM_RELU_EN
    lane_fn = v[LEN_OUT-1] ? '0 : v;
`else
    lane_fn = v;
`endif
  endfunction

  assign pop          = !fifo_empty && out_wr_ready;
  assign out_wr_valid = !fifo_empty;
  assign out_overflow = overflow_q;
  assign out_done     = (state_q == ST_DONE);
  assign {out_wr_addr, out_wr_data, out_wr_mask} = rd_word;

  always_comb begin
    lane0       = lane_fn(in_data0);
    lane1       = lane_fn(in_data1);
    state_d     = state_q;
    beat_d      = beat_q;
    row_d       = row_q;
    kernel_d    = kernel_q;
    kcount_d    = kcount_q;
    addr_d      = addr_q;
    carry0_d    = carry0_q;
    carry1_d    = carry1_q;
    carry2_d    = carry2_q;
    tail_d      = tail_q;
    last_tail_d = last_tail_q;
    push        = 1'b0;
    flush       = 1'b0;
    push_addr   = addr_q;
    push_data   = '0;
    push_mask   = '0;
    beat_fire   = in_write_ctl && (state_q == ST_ARMED);
    last_row    = (row_q == RW'(NUM_ROWS - 1));
    last_kernel = (kernel_q == (kcount_q - 6'd1));

    // Tail word reads the old carry0 while a following beat 0 may overwrite it this cycle.
    if (tail_q) begin
      push        = 1'b1;
      push_data   = {{(3 * LEN_OUT){1'b0}}, carry0_q};
      push_mask   = 4'b0001;
      addr_d      = addr_q + ADDR_W'(1);
      tail_d      = 1'b0;
      last_tail_d = 1'b0;
      if (last_tail_q) begin
        state_d = ST_DRAIN;
      end
    end

    if (beat_fire) begin
      if (beat_q == '0) begin
        carry0_d = lane0;
      end else if (beat_q[0]) begin
        carry1_d = lane0;
        carry2_d = lane1;
      end else begin
        push      = 1'b1;
        push_data = {lane0, carry2_q, carry1_q, carry0_q};
        push_mask = 4'b1111;
        addr_d    = addr_q + ADDR_W'(4);
        carry0_d  = lane1;
      end
      if (beat_q == BW'(BEATS - 1)) begin
        beat_d      = '0;
        tail_d      = 1'b1;
        last_tail_d = last_row && last_kernel;
        if (last_row) begin
          row_d    = '0;
          kernel_d = kernel_q + 6'd1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    overflow_d = overflow_q || (push && fifo_full && !pop);

    case (state_q)
      ST_DRAIN: begin
        if (fifo_empty || ((fifo_count == CW'(1)) && pop)) begin
          state_d = ST_DONE;
        end
      end
      default: ;
    endcase

    if (in_start) begin
      state_d     = ST_ARMED;
      beat_d      = '0;
      row_d       = '0;
      kernel_d    = '0;
      kcount_d    = decode_kernels(in_cfg_co);
      addr_d      = '0;
      tail_d      = 1'b0;
      last_tail_d = 1'b0;
      overflow_d  = 1'b0;
      push        = 1'b0;
      flush       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      row_q       <= '0;
      kernel_q    <= '0;
      kcount_q    <= 6'd8;
      addr_q      <= '0;
      carry0_q    <= '0;
      carry1_q    <= '0;
      carry2_q    <= '0;
      tail_q      <= 1'b0;
      last_tail_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      row_q       <= row_d;
      kernel_q    <= kernel_d;
      kcount_q    <= kcount_d;
      addr_q      <= addr_d;
      carry0_q    <= carry0_d;
      carry1_q    <= carry1_d;
      carry2_q    <= carry2_d;
      tail_q      <= tail_d;
      last_tail_q <= last_tail_d;
      overflow_q  <= overflow_d;
    end
  end

  ofm_wr_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .wdata({push_addr, push_data, push_mask}),
    .rdata(rd_word),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Directed/random bench for ofm_writeback_packer against a column-level packing model.
module tb_ofm_writeback_packer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [2:0]         in_cfg_co;
  logic               in_start;
  logic               in_write_ctl;
  logic signed [24:0] in_data0;
  logic signed [24:0] in_data1;
  logic               out_wr_valid;
  logic               out_wr_ready;
  logic [16:0]        out_wr_addr;
  logic [99:0]        out_wr_data;
  logic [3:0]         out_wr_mask;
  logic               out_overflow;
  logic               out_done;

  always #5 clk = ~clk;

  ofm_writeback_packer #(
    .LEN_OUT(25), .ROW_LEN(61), .NUM_ROWS(61), .FIFO_DEPTH(4), .ADDR_W(17)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_cfg_co(in_cfg_co), .in_start(in_start),
    .in_write_ctl(in_write_ctl), .in_data0(in_data0), .in_data1(in_data1),
    .out_wr_valid(out_wr_valid), .out_wr_ready(out_wr_ready), .out_wr_addr(out_wr_addr),
    .out_wr_data(out_wr_data), .out_wr_mask(out_wr_mask), .out_overflow(out_overflow),
    .out_done(out_done)
  );

  typedef struct {
    logic [16:0] addr;
    logic [99:0] data;
    logic [3:0]  mask;
  } word_t;

  word_t       expq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pops;
  bit          mon_en;
  bit          rdy;
  bit          rdy_rand;
  bit          first_seen;
  bit          done_s;
  logic [16:0] first_addr, last_addr;
  logic [99:0] first_data, last_data;
  logic [3:0]  first_mask, last_mask;
  int          v[61];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd25();
    return int'($urandom_range(0, 33554431)) - 16777216;
  endfunction

  function automatic logic [24:0] mdl_lane(input int x);
`ifdef OFM_RELU_EN
    return (x < 0) ? 25'd0 : 25'(x);
`else
    return 25'(x);
`endif
  endfunction

  // Row of 61 columns -> 15 full words of 4 consecutive columns, then a single-column tail.
  task automatic model_row(input int base, input int vals[61]);
    word_t e;
    for (int w = 0; w < 15; w++) begin
      e.addr = 17'(base + 4 * w);
      e.data = {mdl_lane(vals[4*w+3]), mdl_lane(vals[4*w+2]), mdl_lane(vals[4*w+1]), mdl_lane(vals[4*w])};
      e.mask = 4'hF;
      expq.push_back(e);
    end
    e.addr = 17'(base + 60);
    e.data = {75'd0, mdl_lane(vals[60])};
    e.mask = 4'h1;
    expq.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit wc, input int d0, input int d1);
    in_start     = st;
    in_write_ctl = wc;
    in_data0     = 25'(d0);
    in_data1     = 25'(d1);
    out_wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy;
    @(negedge clk);
    done_s = out_done;
    if (mon_en && out_wr_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_word", expq.size(), 1);
      end else begin
        chk("word_addr", out_wr_addr, expq[0].addr);
        chk("word_data", out_wr_data, expq[0].data);
        chk("word_mask", out_wr_mask, expq[0].mask);
        if (out_wr_ready) begin
          void'(expq.pop_front());
          n_pops++;
          if (!first_seen) begin
            first_seen = 1'b1;
            first_addr = out_wr_addr;
            first_data = out_wr_data;
            first_mask = out_wr_mask;
          end
          last_addr = out_wr_addr;
          last_data = out_wr_data;
          last_mask = out_wr_mask;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input int vals[61], input int gap, input int stall_from, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (b >= stall_from) rdy = 1'b0;
      if (b == 0) cyc(1'b0, 1'b1, vals[0], rnd25());
      else        cyc(1'b0, 1'b1, vals[2*b-1], vals[2*b]);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, rnd25(), rnd25());
    end
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int i = 0; i < limit && expq.size() != 0; i++) cyc(1'b0, 1'b0, 0, 0);
    chk(tag, expq.size(), 0);
  endtask

  task automatic start_run();
    expq.delete();
    n_pops     = 0;
    first_seen = 1'b0;
    cyc(1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_cfg_co = 3'd0; in_start = 1'b0; in_write_ctl = 1'b0;
    in_data0 = '0; in_data1 = '0; out_wr_ready = 1'b1;
    rdy = 1'b1; rdy_rand = 1'b0; mon_en = 1'b0; n_pops = 0; first_seen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", out_wr_valid, 0);
    chk("reset_addr", out_wr_addr, 0);
    chk("reset_data", out_wr_data, 0);
    chk("reset_mask", out_wr_mask, 0);
    chk("reset_overflow", out_overflow, 0);
    chk("reset_done", out_done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single row, column c carries c+1
    mon_en = 1'b1;
    start_run();
    for (int c = 0; c < 61; c++) v[c] = c + 1;
    model_row(0, v);
    drive_row(v, 0, 99, 31);
    wait_drain("row_drain", 50);
    chk("row_words", n_pops, 16);
    chk("row_first_addr", first_addr, 0);
    chk("row_first_data", first_data, {25'd4, 25'd3, 25'd2, 25'd1});
    chk("row_first_mask", first_mask, 4'hF);
    chk("row_last_addr", last_addr, 60);
    chk("row_last_data", last_data, 100'd61);
    chk("row_last_mask", last_mask, 4'h1);

    // Full run, 8 kernels, back-to-back rows
    start_run();
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 61; r++) begin
        for (int c = 0; c < 61; c++) v[c] = rnd25();
        model_row(k * 3721 + r * 61, v);
        drive_row(v, 0, 99, 31);
      end
    end
    wait_drain("full_drain", 50);
    chk("full_done_before_last_pop", done_s, 0);
    @(negedge clk);
    chk("full_done", out_done, 1);
    chk("full_valid_after", out_wr_valid, 0);
    chk("full_overflow", out_overflow, 0);
    chk("full_words", n_pops, 7808);
    chk("full_last_addr", last_addr, 29767);
    @(posedge clk); #1;

    // Stalled sink for a whole row: first four words survive
    rdy = 1'b0;
    start_run();
    chk("start_clears_done", out_done, 0);
    for (int c = 0; c < 61; c++) v[c] = rnd25();
    model_row(0, v);
    while (expq.size() > 4) void'(expq.pop_back());
    drive_row(v, 0, 0, 31);
    cyc(1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0);
    chk("ovf_sticky_set", out_overflow, 1);
    chk("ovf_done", out_done, 0);
    rdy = 1'b1;
    wait_drain("ovf_drain", 20);
    repeat (3) cyc(1'b0, 1'b0, 0, 0);
    chk("ovf_words", n_pops, 4);
    chk("ovf_still_set", out_overflow, 1);

    // Signed lanes with gaps between beats and random ready
    rdy_rand = 1'b1;
    start_run();
    chk("start_clears_overflow", out_overflow, 0);
    for (int c = 0; c < 61; c++) v[c] = (c % 2 == 0) ? -5 : 7;
    model_row(0, v);
    drive_row(v, 2, 99, 31);
    wait_drain("neg_drain", 200);
    rdy_rand = 1'b0;
    rdy = 1'b1;
`ifdef OFM_RELU_EN
    chk("neg_lane0", first_data[24:0], 25'd0);
`else
    chk("neg_lane0", first_data[24:0], 25'h1FFFFFB);
`endif
    chk("neg_lane1", first_data[49:25], 25'd7);

    // Asynchronous reset at beat 15 of row 3 with a full FIFO
    mon_en = 1'b0;
    rdy = 1'b0;
    start_run();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 61; c++) v[c] = rnd25();
      drive_row(v, 0, 0, 31);
    end
    drive_row(v, 0, 0, 15);
    in_write_ctl = 1'b1; in_data0 = 25'(rnd25()); in_data1 = 25'(rnd25());
    chk("pre_reset_valid", out_wr_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_wr_valid, 0);
    chk("async_rst_addr", out_wr_addr, 0);
    chk("async_rst_data", out_wr_data, 0);
    chk("async_rst_mask", out_wr_mask, 0);
    chk("async_rst_overflow", out_overflow, 0);
    chk("async_rst_done", out_done, 0);
    in_write_ctl = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b1;
    mon_en = 1'b1;
    start_run();
    for (int c = 0; c < 61; c++) v[c] = rnd25();
    model_row(0, v);
    drive_row(v, 0, 99, 31);
    wait_drain("post_rst_drain", 50);
    chk("post_rst_first_addr", first_addr, 0);
    chk("post_rst_words", n_pops, 16);

    // in_start during DRAIN with two words held
    start_run();
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < 61; r++) begin
        for (int c = 0; c < 61; c++) v[c] = rnd25();
        model_row(k * 3721 + r * 61, v);
        drive_row(v, 0, (k == 7 && r == 60) ? 30 : 99, 31);
      end
    end
    cyc(1'b0, 1'b0, 0, 0);
    chk("drain_words_held", expq.size(), 2);
    @(negedge clk);
    chk("drain_valid", out_wr_valid, 1);
    chk("drain_not_done", out_done, 0);
    @(posedge clk); #1;
    mon_en = 1'b0;
    start_run();
    @(negedge clk);
    chk("restart_valid", out_wr_valid, 0);
    chk("restart_overflow", out_overflow, 0);
    chk("restart_done", out_done, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    rdy = 1'b1;
    for (int c = 0; c < 61; c++) v[c] = rnd25();
    model_row(0, v);
    drive_row(v, 0, 99, 31);
    wait_drain("restart_drain", 50);
    chk("restart_first_addr", first_addr, 0);
    chk("restart_words", n_pops, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ofm_writeback_packer.md
# ofm_writeback_packer

Downstream stage of the convolution top module. Consumes the per-row output stream (`write_ctl` plus two 25-bit lanes, one value on the first beat of each row and two on the remaining 30) and packs it into 4-lane, address-tagged words for the output-feature-map SRAM. A valid/ready handshake, a small FIFO and sticky overflow reporting decouple it from the SRAM, because the upstream module has no backpressure.

## Interface
- `LEN_OUT`, 25, bit width of one output element.
- `ROW_LEN`, 61, output columns per row.
- `NUM_ROWS`, 61, output rows per kernel.
- `FIFO_DEPTH`, 4, packed-word FIFO entries.
- `ADDR_W`, 17, element address width (32·3721 < 2^17).
- `clk` input 1, single clock; all logic on rising edge.
- `rst_n` input 1, asynchronous active-low reset.
- `in_cfg_co` input 3, kernel count: 0=8, 1=16, 2=24, 3=32, others=32; sampled at `in_start`.
- `in_start` input 1, one-cycle pulse that clears counters and FIFO and arms the block.
- `in_write_ctl` input 1, upstream output beat valid.
- `in_data0` input LEN_OUT, signed, lane 0 (always valid on a beat).
- `in_data1` input LEN_OUT, signed, lane 1 (ignored on beat 0 of a row).
- `out_wr_valid` output 1, packed word available.
- `out_wr_ready` input 1, SRAM accepts word.
- `out_wr_addr` output ADDR_W, element address of lane 0.
- `out_wr_data` output 4·LEN_OUT, lane i in bits [i·25+24 : i·25].
- `out_wr_mask` output 4, lane-valid mask.
- `out_overflow` output 1, sticky: a word was dropped.
- `out_done` output 1, level: all words of the last kernel have been popped.

## Operation
- FSM states:
  - IDLE → ARMED on `in_start`.
  - ARMED → DRAIN after the tail word of row 60 of kernel co-1 has been pushed.
  - DRAIN → DONE when the FIFO is empty.
  - DONE → ARMED on `in_start`.
  - `in_start` in any state returns to ARMED: counters zeroed, FIFO flushed, `out_overflow` and `out_done` cleared.
- Beats with `in_write_ctl` are ignored outside ARMED.
- Counters: beat (0..30), row (0..60), kernel (0..co-1). Beat 30 wraps the beat counter and advances the row; row 60 wrapping advances the kernel.
- Column accounting:
  - Beat 0 supplies column 0 from `in_data0`.
  - Beat b≥1 supplies columns 2b-1 (`in_data0`) and 2b (`in_data1`).
- A carry register holds up to 3 pending columns.
  - Even beats b≥2 complete the word for columns 2b-4..2b-1 (mask 1111) and leave column 2b as carry.
  - The tail word (column 60 only, mask 0001) is pushed the cycle after beat 30.
  - 16 words per row.
- Address = kernel·3721 + row·61 + first column, computed with an incremental adder (no multiplier).
- FIFO:
  - `out_wr_valid` = not empty; pop on `out_wr_valid & out_wr_ready`.
  - Push while full with a simultaneous pop is accepted.
  - Push while full without a pop drops the new word and sets `out_overflow`.
- Output data lanes pass through unmodified (no rounding or saturation) unless `OFM_RELU_EN` is defined.

## Timing
- Reset values: `out_wr_valid`=0, `out_wr_addr`=0, `out_wr_data`=0, `out_wr_mask`=0, `out_overflow`=0, `out_done`=0; FSM=IDLE.
- Latency: a word completed on beat b appears on `out_wr_valid` the cycle after the beat's edge, if the FIFO was empty.
- Tail push never collides with another push: beats 0 and 1 never complete a word, so next-row beat 0 may immediately follow beat 30.
- `out_wr_addr`/`out_wr_data`/`out_wr_mask` hold stable while `out_wr_valid` is high and `out_wr_ready` is low.
- `out_done` rises the cycle after the final pop.
- Reset mid-operation: immediate return to IDLE, FIFO contents discarded.

## Configuration
- `OFM_RELU_EN` defined: each lane is clamped to 0 when negative, before packing. Masked-off lanes are 0 regardless.
- `OFM_RELU_EN` undefined: values pass through bit-exact.

## Structure
- Package `ofm_pkg`:
  - constants `ROW_LEN`, `NUM_ROWS`, `OFM_PLANE`=3721, `BEATS_PER_ROW`=31;
  - function decoding `in_cfg_co` to a kernel count.
- Sub-module `ofm_wr_fifo`: synchronous FIFO, FIFO_DEPTH × (ADDR_W+4·LEN_OUT+4) bits, with full/empty flags and push-while-full-with-pop support.

## Test plan
- Single row, cfg_co=0, ready=1, column c value = c+1:
  - 16 words; first addr 0, data {4,3,2,1}, mask 1111;
  - last addr 60, data lane0 = 61, mask 0001.
- Full run, cfg_co=0, 8·61 rows, ready=1 → 7808 words; last addr 8·3721-61+60 = 29767; `out_done`=1 one cycle after the final pop; `out_overflow`=0.
- `out_wr_ready`=0 for a whole row → exactly 4 words held, 12 dropped, `out_overflow`=1; the held first word stays stable.
- `OFM_RELU_EN`, inputs −5 and 7 → lanes 0 and 7; without the macro → −5 (25-bit two's complement 0x1FFFFFB) and 7.
- `rst_n` low at beat 15 of row 3 → all outputs 0 asynchronously; after release, `in_start` and a fresh row give first addr 0.
- `in_start` during DRAIN with 2 FIFO entries → FIFO emptied, `out_wr_valid`=0 next cycle, counters restart at 0.
